// File: rtl/noc_pkg.sv
// Shared NoC router definitions: default flit geometry, port indices, flit type
// and the input-buffer handshake states.
package noc_pkg;
  localparam int NOC_DATA_WIDTH = 32;
  localparam int NOC_FIFO_DEPTH = 4;
  localparam int NUM_PORTS      = 5;

  typedef enum logic [2:0] {PORT_N, PORT_E, PORT_W, PORT_S, PORT_L} port_e;

  typedef logic [NOC_DATA_WIDTH-1:0] flit_t;

  typedef enum logic {ST_IDLE, ST_ACK} hs_state_e;
endpackage

// File: rtl/input_fifo_if.sv
// Input-port bundle: upstream RTS/CTS link, arbiter grants, and the head-flit view
// presented to routing/arbitration.
interface input_fifo_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] RX;
  logic                  DRTS;
  logic                  CTS;
  logic                  read_en_N, read_en_E, read_en_W, read_en_S, read_en_L;
  logic [DATA_WIDTH-1:0] Data_out;
  logic                  empty;
  logic                  full;
  logic                  err_underflow;

  modport slave (
    input  RX, DRTS, read_en_N, read_en_E, read_en_W, read_en_S, read_en_L,
    output CTS, Data_out, empty, full, err_underflow
  );

  modport master (
    output RX, DRTS, read_en_N, read_en_E, read_en_W, read_en_S, read_en_L,
    input  CTS, Data_out, empty, full, err_underflow
  );
endinterface

// File: rtl/input_fifo.sv
// Router input buffer: RTS/CTS capture into a small show-ahead FIFO, popped by any
// output arbiter grant. Underflow attempts are latched in a sticky error flag.
module input_fifo
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH = NOC_DATA_WIDTH,
  parameter int DEPTH      = NOC_FIFO_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input_fifo_if.slave  bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  // Explicit wrap so non-power-of-two depths stay inside the array.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  hs_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  ptr_t                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  cnt_t                  count_q, count_d;
  logic                  err_q, err_d;

  logic                  cts, empty, full, wr_en, rd_req, rd_en;
  logic [NUM_PORTS-1:0]  grant;

  assign empty = (count_q == '0);
  assign full  = (count_q == cnt_t'(DEPTH));

  assign grant[PORT_N] = bus.read_en_N;
  assign grant[PORT_E] = bus.read_en_E;
  assign grant[PORT_W] = bus.read_en_W;
  assign grant[PORT_S] = bus.read_en_S;
  assign grant[PORT_L] = bus.read_en_L;

  // Arbiters are mutually exclusive; several grants at once still pop one flit.
  assign rd_req = |grant;
  assign rd_en  = rd_req & ~empty;
  assign wr_en  = bus.DRTS & ~cts & ~full;

  // Handshake FSM: state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Handshake FSM: next state. ACK lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.DRTS && !full) state_d = ST_ACK;
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake FSM: outputs.
  always_comb begin
    cts = (state_q == ST_ACK);
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    err_d    = err_q | (rd_req & empty);
    if (wr_en) begin
      mem_d[wr_ptr_q] = bus.RX;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (rd_en) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + cnt_t'(1);
      2'b01:   count_d = count_q - cnt_t'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  assign bus.CTS           = cts;
  assign bus.Data_out      = mem_q[rd_ptr_q];
  assign bus.empty         = empty;
  assign bus.full          = full;
  assign bus.err_underflow = err_q;
endmodule
